// File: rtl/store_narrower_pkg.sv
// rtl/store_narrower_pkg.sv - size encodings, FSM states and accept routing for the store narrower
package store_narrower_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR,
        DONE,
        ERR
    } state_e;

    // Aligned words write straight through; sub-word stores need a read-modify-write.
    function automatic state_e accept_target(size_e size, logic [1:0] lane);
        state_e tgt;
        tgt = ERR;
        case (size)
            SZ_WORD: if (lane == 2'b00) tgt = WR;
            SZ_HALF: if (!lane[0]) tgt = RD_REQ;
            SZ_BYTE: tgt = RD_REQ;
            default: tgt = ERR;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/store_narrower_if.sv
// rtl/store_narrower_if.sv - request and word-memory signals of the store narrower
interface store_narrower_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic              mem_rd_valid;
    logic [31:0]       mem_rd_data;
    logic              mem_wr_en;
    logic [31:0]       mem_wr_data;
    logic              mem_wr_ack;
    logic              done;
    logic              misalign_err;

    modport slave (
        input  req_valid, req_addr, req_data, req_size,
        input  mem_rd_valid, mem_rd_data, mem_wr_ack,
        output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        output done, misalign_err
    );

    modport master (
        output req_valid, req_addr, req_data, req_size,
        output mem_rd_valid, mem_rd_data, mem_wr_ack,
        input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        input  done, misalign_err
    );
endinterface

// File: rtl/store_narrower_merge.sv
// rtl/store_narrower_merge.sv - little-endian byte/half lane merge into a read word
module byte_lane_merge
    import store_narrower_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [15:0] new_data,
    input  size_e       size,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0: merged[7:0]   = new_data[7:0];
                    2'd1: merged[15:8]  = new_data[7:0];
                    2'd2: merged[23:16] = new_data[7:0];
                    default: merged[31:24] = new_data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) merged[31:16] = new_data;
                else         merged[15:0]  = new_data;
            end
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_narrower.sv
// rtl/store_narrower.sv - narrows byte/half/word stores onto a word-only memory via read-modify-write
module store_narrower
    import store_narrower_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic            clk,
    input logic            rst_n,
    store_narrower_if.slave bus
);

    state_e      state;
    state_e      state_nxt;
    size_e       size_q;
    logic [1:0]  lane_q;
    logic [15:0] data_q;
    logic [31:0] merged;
    logic        accept;

    assign accept = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        bus.req_ready    = 1'b0;
        bus.mem_rd_en    = 1'b0;
        bus.mem_wr_en    = 1'b0;
        bus.done         = 1'b0;
        bus.misalign_err = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    state_nxt = accept_target(size_e'(bus.req_size), bus.req_addr[1:0]);
            end
            RD_REQ: begin
                bus.mem_rd_en = 1'b1;
                state_nxt     = RD_WAIT;
            end
            RD_WAIT: if (bus.mem_rd_valid) state_nxt = WR;
            WR: begin
                bus.mem_wr_en = 1'b1;
                if (bus.mem_wr_ack) state_nxt = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                bus.misalign_err = 1'b1;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    byte_lane_merge u_merge (
        .old_word (bus.mem_rd_data),
        .new_data (data_q),
        .size     (size_q),
        .lane     (lane_q),
        .merged   (merged)
    );

    // Word data is latched at accept; sub-word stores overwrite it with the merged word later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.mem_addr    <= '0;
            bus.mem_wr_data <= '0;
            size_q          <= SZ_BYTE;
            lane_q          <= 2'b00;
            data_q          <= '0;
        end else begin
            if (accept) begin
                bus.mem_addr    <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                bus.mem_wr_data <= bus.req_data;
                size_q          <= size_e'(bus.req_size);
                lane_q          <= bus.req_addr[1:0];
                data_q          <= bus.req_data[15:0];
            end
            if (state == RD_WAIT && bus.mem_rd_valid)
                bus.mem_wr_data <= merged;
        end
    end

endmodule
